// File: rtl/sid_table_sched.sv
// rtl/sid_table_sched.sv - time-multiplexed SID waveform/filter/DAC table lookup sequencer
module sid_table_sched #(
  parameter int  DUAL    = 1,
  parameter int  TBL_LAT = 2,
  localparam int N       = (DUAL != 0) ? 2 : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_1m,
  input  logic [36*N-1:0]   acc_ps_in,
  input  logic [36*N-1:0]   acc_t_in,
  input  logic [11*N-1:0]   fc_in,
  input  logic [8*N-1:0]    vol_in,
  input  logic [N-1:0]      mode_in,
  input  logic [2*N-1:0]    cfg_in,
  output logic [11:0]       tbl_acc_ps,
  output logic [11:0]       tbl_acc_t,
  output logic [10:0]       tbl_fc,
  output logic [1:0]        tbl_cfg,
  output logic [7:0]        tbl_dac_addr,
  output logic              tbl_mode,
  input  logic [31:0]       tbl_wave,
  input  logic [17:0]       tbl_f0,
  input  logic [17:0]       tbl_dac,
  output logic [96*N-1:0]   wave_out,
  output logic [18*N-1:0]   f0_out,
  output logic [18*N-1:0]   dac_out,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  input  logic              overrun_clr
);
  localparam int         S     = 4 * N;
  localparam int         WW    = 96 * N;
  localparam int         FW    = 18 * N;
  localparam logic [3:0] LAT_C = 4'(TBL_LAT);
  localparam logic [3:0] SL_C  = 4'(S - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_COMMIT} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [36*N-1:0]   r_snap_ps, r_snap_t;
  logic [11*N-1:0]   r_snap_fc;
  logic [8*N-1:0]    r_snap_vol;
  logic [N-1:0]      r_snap_mode;
  logic [2*N-1:0]    r_snap_cfg;
  logic [WW-1:0]     r_sh_wave;
  logic [FW-1:0]     r_sh_f0, r_sh_dac;

  logic              w_idle, w_run, w_pen, w_cap, w_last, w_cfilt;
  logic [3:0]        w_pslot, w_cidx, w_pvi, w_cvi;
  logic [1:0]        w_pchip, w_cchip;
  logic [8:0]        w_wsh;
  logic [7:0]        w_fsh;
  logic [36*N-1:0]   w_src_ps, w_src_t;
  logic [11*N-1:0]   w_src_fc;
  logic [8*N-1:0]    w_src_vol;
  logic [N-1:0]      w_src_mode;
  logic [2*N-1:0]    w_src_cfg;
  logic [11:0]       w_sel_ps, w_sel_t;
  logic [10:0]       w_sel_fc;
  logic [7:0]        w_sel_vol;
  logic [1:0]        w_sel_cfg;
  logic              w_sel_mode;
  logic [WW-1:0]     w_wave_nx;
  logic [FW-1:0]     w_f0_nx, w_dac_nx;

  // Slot addressing and result capture; slot 0 is fed straight from the inputs on the start edge
  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_run      = (r_state == S_RUN);
    w_src_ps   = w_idle ? acc_ps_in : r_snap_ps;
    w_src_t    = w_idle ? acc_t_in  : r_snap_t;
    w_src_fc   = w_idle ? fc_in     : r_snap_fc;
    w_src_vol  = w_idle ? vol_in    : r_snap_vol;
    w_src_mode = w_idle ? mode_in   : r_snap_mode;
    w_src_cfg  = w_idle ? cfg_in    : r_snap_cfg;

    w_pslot    = w_idle ? 4'd0 : r_cnt + 4'd1;
    w_pen      = (w_idle && ce_1m) || (w_run && (r_cnt < SL_C));
    w_pchip    = w_pslot[3:2];
    w_pvi      = 4'(w_pchip) * 4'd3 + 4'(w_pslot[1:0]);
    w_sel_ps   = 12'(w_src_ps >> (8'(w_pvi) * 8'd12));
    w_sel_t    = 12'(w_src_t >> (8'(w_pvi) * 8'd12));
    w_sel_fc   = 11'(w_src_fc >> (8'(w_pchip) * 8'd11));
    w_sel_vol  = 8'(w_src_vol >> {w_pchip, 3'b000});
    w_sel_cfg  = 2'(w_src_cfg >> {w_pchip, 1'b0});
    w_sel_mode = 1'(w_src_mode >> w_pchip);

    // Result of slot k arrives TBL_LAT cycles after it was presented
    w_cidx     = r_cnt - LAT_C;
    w_cap      = w_run && (r_cnt >= LAT_C) && (w_cidx <= SL_C);
    w_last     = w_cap && (w_cidx == SL_C);
    w_cchip    = w_cidx[3:2];
    w_cfilt    = &w_cidx[1:0];
    w_cvi      = 4'(w_cchip) * 4'd3 + 4'(w_cidx[1:0]);
    w_wsh      = {w_cvi, 5'b00000};
    w_fsh      = 8'(w_cchip) * 8'd18;

    w_wave_nx  = r_sh_wave;
    w_f0_nx    = r_sh_f0;
    w_dac_nx   = r_sh_dac;
    if (w_cap && !w_cfilt) begin
      w_wave_nx = (r_sh_wave & ~(WW'(32'hFFFF_FFFF) << w_wsh)) | (WW'(tbl_wave) << w_wsh);
    end
    if (w_cap && w_cfilt) begin
      w_f0_nx  = (r_sh_f0 & ~(FW'(18'h3FFFF) << w_fsh)) | (FW'(tbl_f0) << w_fsh);
      w_dac_nx = (r_sh_dac & ~(FW'(18'h3FFFF) << w_fsh)) | (FW'(tbl_dac) << w_fsh);
    end
  end

  // Sequencer FSM; committed outputs load on the edge into COMMIT so they are valid while done is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_snap_ps    <= '0;
      r_snap_t     <= '0;
      r_snap_fc    <= '0;
      r_snap_vol   <= '0;
      r_snap_mode  <= '0;
      r_snap_cfg   <= '0;
      r_sh_wave    <= '0;
      r_sh_f0      <= '0;
      r_sh_dac     <= '0;
      tbl_acc_ps   <= '0;
      tbl_acc_t    <= '0;
      tbl_fc       <= '0;
      tbl_cfg      <= '0;
      tbl_dac_addr <= '0;
      tbl_mode     <= 1'b0;
      wave_out     <= '0;
      f0_out       <= '0;
      dac_out      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!w_idle && ce_1m) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      if (w_pen) begin
        tbl_mode <= w_sel_mode;
        if (&w_pslot[1:0]) begin
          tbl_fc       <= w_sel_fc;
          tbl_cfg      <= w_sel_cfg;
          tbl_dac_addr <= w_sel_vol;
        end else begin
          tbl_acc_ps   <= w_sel_ps;
          tbl_acc_t    <= w_sel_t;
        end
      end

      r_sh_wave <= w_wave_nx;
      r_sh_f0   <= w_f0_nx;
      r_sh_dac  <= w_dac_nx;

      case (r_state)
        S_IDLE: begin
          if (ce_1m) begin
            r_snap_ps   <= acc_ps_in;
            r_snap_t    <= acc_t_in;
            r_snap_fc   <= fc_in;
            r_snap_vol  <= vol_in;
            r_snap_mode <= mode_in;
            r_snap_cfg  <= cfg_in;
            r_cnt       <= '0;
            busy        <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            wave_out <= w_wave_nx;
            f0_out   <= w_f0_nx;
            dac_out  <= w_dac_nx;
            done     <= 1'b1;
            r_state  <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
